// File: rtl/fifo_cond_pkg.sv
// Shared defaults for the conditioned FIFO.
// Consumers import this package for widths, thresholds and the count-width helper.
package fifo_cond_pkg;
  localparam int DATA_WIDTH_DEF   = 10;
  localparam int ADDR_WIDTH_DEF   = 3;
  localparam int ALM_FULL_TH_DEF  = 6;
  localparam int ALM_EMPTY_TH_DEF = 1;
  localparam int COUNT_W_DEF      = ADDR_WIDTH_DEF + 1;

  // count needs one extra bit so that "full" (== depth) is representable
  function automatic int count_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/fifo_cond_mem_dp.sv
// Simple dual-port register file: one write port, one registered read port.
// The storage array is never reset; only the read register clears.
module mem_dp #(
  parameter int DW = 10,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // read-before-write: a same-address write in this cycle is not forwarded
  always_ff @(posedge clk) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo_cond.sv
// Single-clock FIFO with occupancy counter, threshold flags and sticky error.
// All outputs come from registers or decode of the registered count.
module fifo_cond
  import fifo_cond_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int ALM_FULL_TH  = ALM_FULL_TH_DEF,
  parameter int ALM_EMPTY_TH = ALM_EMPTY_TH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid_out,
  output logic                     empty,
  output logic                     full,
  output logic                     alm_full,
  output logic                     alm_empty,
  output logic                     error,
  output logic [ADDR_WIDTH:0]      count
);
  localparam int CW    = count_w(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  vld, err;
  logic                  pop_ok, push_ok;

  // a pop frees a slot this edge, so push is legal when full if pop is too
  assign pop_ok  = pop && (cnt != '0);
  assign push_ok = push && ((cnt != CW'(DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      vld <= pop_ok;
      if ((push && !push_ok) || (pop && !pop_ok)) err <= 1'b1;
    end
  end

  mem_dp #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push_ok && rst),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

  assign valid_out = vld;
  assign error     = err;
  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign alm_full  = (cnt >= CW'(ALM_FULL_TH));
  assign alm_empty = (cnt <= CW'(ALM_EMPTY_TH));
endmodule

// File: tb/tb_fifo_cond.sv
// Bench for fifo_cond: vector table plus a read-data scoreboard fed by a
// reference FIFO model; hand sequences cover overflow, empty push+pop, reset.
module tb_fifo_cond;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0, pop = 1'b0;
  logic [9:0] data_in = '0;
  logic [9:0] data_out;
  logic       valid_out, empty, full, alm_full, alm_empty, error;
  logic [3:0] count;

  fifo_cond dut (
    .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .empty(empty), .full(full),
    .alm_full(alm_full), .alm_empty(alm_empty), .error(error), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       p;
    logic       q;
    logic [9:0] d;
    int         ec;
    logic       ee;
  } vec_t;

  vec_t       tbl[$];
  logic [9:0] m[$];    // reference FIFO contents
  logic [9:0] sb[$];   // expected read words, oldest first
  logic [9:0] last_out = '0;
  int         n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  // {empty, full, alm_full, alm_empty} for depth 8, thresholds 6 and 1
  function automatic logic [3:0] flags(input int c);
    return {c == 0, c == 8, c >= 6, c <= 1};
  endfunction

  function automatic void addv(input logic p, input logic q, input logic [9:0] d, input int ec, input logic ee);
    vec_t v;
    v.p = p; v.q = q; v.d = d; v.ec = ec; v.ee = ee;
    tbl.push_back(v);
  endfunction

  task automatic apply(input logic p, input logic q, input logic [9:0] d, input int ec, input logic ee, input string nm);
    logic pa, wa;
    logic [9:0] ed;
    @(negedge clk);
    push = p; pop = q; data_in = d;
    pa = q && (m.size() > 0);
    wa = p && ((m.size() < 8) || pa);
    if (pa) sb.push_back(m.pop_front());
    if (wa) m.push_back(d);
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    chk(nm, "count", 32'(count), 32'(ec));
    chk(nm, "flags", 32'({empty, full, alm_full, alm_empty}), 32'(flags(ec)));
    chk(nm, "error", 32'(error), 32'(ee));
    chk(nm, "valid_out", 32'(valid_out), 32'(pa));
    if (valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL %s.data_out: unexpected word %0h, none expected", nm, data_out);
      end else begin
        ed = sb.pop_front();
        chk(nm, "data_out", 32'(data_out), 32'(ed));
        last_out = ed;
      end
    end else begin
      chk(nm, "data_hold", 32'(data_out), 32'(last_out));
    end
  endtask

  task automatic do_reset(input logic p, input logic q, input string nm);
    @(negedge clk);
    rst = 1'b0; push = p; pop = q; data_in = 10'h2AA;
    @(posedge clk); #1;
    rst = 1'b1; push = 1'b0; pop = 1'b0;
    m.delete(); sb.delete(); last_out = '0;
    chk(nm, "count", 32'(count), 32'd0);
    chk(nm, "flags", 32'({empty, full, alm_full, alm_empty}), 32'(4'b1001));
    chk(nm, "error", 32'(error), 32'd0);
    chk(nm, "valid_out", 32'(valid_out), 32'd0);
    chk(nm, "data_out", 32'(data_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // offset pointers by 3 so the following fill/drain crosses the wrap point
    for (int i = 1; i <= 3; i++) addv(1'b1, 1'b0, 10'(32'h0A0 + i), i, 1'b0);
    for (int i = 1; i <= 3; i++) addv(1'b0, 1'b1, 10'h000, 3 - i, 1'b0);
    for (int i = 1; i <= 8; i++) addv(1'b1, 1'b0, 10'(i), i, 1'b0);
    for (int i = 1; i <= 8; i++) addv(1'b0, 1'b1, 10'h000, 8 - i, 1'b0);

    do_reset(1'b0, 1'b0, "reset");
    repeat (2) @(negedge clk);
    chk("idle", "count", 32'(count), 32'd0);
    chk("idle", "flags", 32'({empty, full, alm_full, alm_empty}), 32'(4'b1001));

    foreach (tbl[i]) apply(tbl[i].p, tbl[i].q, tbl[i].d, tbl[i].ec, tbl[i].ee, $sformatf("vec%0d", i));

    // overflow: extra push while full is dropped, error sticks through the drain
    for (int i = 1; i <= 8; i++) apply(1'b1, 1'b0, 10'(i), i, 1'b0, "refill");
    apply(1'b1, 1'b0, 10'h3FF, 8, 1'b1, "overflow");
    for (int i = 1; i <= 8; i++) apply(1'b0, 1'b1, 10'h000, 8 - i, 1'b1, "drain");
    apply(1'b0, 1'b1, 10'h000, 0, 1'b1, "underflow");
    apply(1'b0, 1'b0, 10'h000, 0, 1'b1, "hold");

    // push+pop on empty: push lands, pop rejected
    do_reset(1'b0, 1'b0, "reset2");
    apply(1'b1, 1'b1, 10'h155, 1, 1'b1, "empty_pp");
    apply(1'b0, 1'b1, 10'h000, 0, 1'b1, "empty_pp_rd");

    // full push+pop: both accepted, count stays at 8
    do_reset(1'b0, 1'b0, "reset3");
    for (int i = 1; i <= 8; i++) apply(1'b1, 1'b0, 10'(32'h200 + i), i, 1'b0, "fill3");
    apply(1'b1, 1'b1, 10'h2FF, 8, 1'b0, "full_pp");
    for (int i = 1; i <= 8; i++) apply(1'b0, 1'b1, 10'h000, 8 - i, 1'b0, "drain3");

    // steady push+pop at 5 entries, then reset mid-stream
    do_reset(1'b0, 1'b0, "reset4");
    for (int i = 1; i <= 5; i++) apply(1'b1, 1'b0, 10'(32'h300 + i), i, 1'b0, "fill5");
    for (int i = 0; i < 10; i++) apply(1'b1, 1'b1, 10'(32'h110 + i), 5, 1'b0, "stream");
    do_reset(1'b1, 1'b1, "reset_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
